// File: rtl/arith_op_scheduler.sv
// arith_op_scheduler: shared iterative multiply/divide engine behind a two-port round-robin arbiter.
// Optional ARITH_SCHED_EARLY_EXIT_EN: multiplies leave RUN once the remaining multiplier bits are zero.
module arith_op_scheduler #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [2:0]      req0_op,
  input  logic [SIZE-1:0] req0_a,
  input  logic [SIZE-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [2:0]      req1_op,
  input  logic [SIZE-1:0] req1_a,
  input  logic [SIZE-1:0] req1_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [SIZE-1:0] rsp_lo,
  output logic [SIZE-1:0] rsp_hi,
  output logic            rsp_err
);
  // state | meaning
  // IDLE  | arbitrate between ports, accept one request
  // PREP  | take operand magnitudes, screen illegal op and divide by zero
  // RUN   | one multiplier bit or one quotient bit per cycle
  // FIX   | apply result signs
  // DONE  | hold response until rsp_ready
  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;
  localparam int CW = $clog2(SIZE + 1);

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [SIZE-1:0]   a_q, a_d, b_q, b_d, opb_q, opb_d;
  logic              id_q, id_d, last_q, last_d, sa_q, sa_d, sb_q, sb_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*SIZE-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d, rsp_err_q, rsp_err_d;
  logic [SIZE-1:0]   rsp_lo_q, rsp_lo_d, rsp_hi_q, rsp_hi_d;

  logic              grant0, grant1, is_signed, is_div, neg_a, neg_b, run_last;
  logic [SIZE-1:0]   mag_a, mag_b, quo, rem;
  logic [2*SIZE:0]   dshift;
  logic [2*SIZE-1:0] prod;

  // last_q set means port 1 was granted last, so port 0 wins a tie
  always_comb begin
    grant0 = (state_q == IDLE) && req0_valid && (!req1_valid || last_q);
    grant1 = (state_q == IDLE) && req1_valid && (!req0_valid || !last_q);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    opb_d       = opb_q;
    id_d        = id_q;
    last_d      = last_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    rsp_lo_d    = rsp_lo_q;
    rsp_hi_d    = rsp_hi_q;

    is_signed = op_q[0];
    is_div    = op_q[1];
    neg_a     = is_signed && a_q[SIZE-1];
    neg_b     = is_signed && b_q[SIZE-1];
    mag_a     = neg_a ? -a_q : a_q;
    mag_b     = neg_b ? -b_q : b_q;

    // restoring divide step: shift in a zero, subtract divisor when it fits
    dshift = {acc_q, 1'b0};
    if (dshift[2*SIZE:SIZE] >= {1'b0, opb_q}) begin
      dshift[2*SIZE:SIZE] = dshift[2*SIZE:SIZE] - {1'b0, opb_q};
      dshift[0]           = 1'b1;
    end

    prod = (is_signed && (sa_q ^ sb_q)) ? -acc_q : acc_q;
    quo  = (is_signed && (sa_q ^ sb_q)) ? -acc_q[SIZE-1:0] : acc_q[SIZE-1:0];
    rem  = (is_signed && sa_q) ? -acc_q[2*SIZE-1:SIZE] : acc_q[2*SIZE-1:SIZE];

    run_last = (cnt_q == CW'(1));
`ifdef ARITH_SCHED_EARLY_EXIT_EN
    if (!is_div && ((opb_q >> 1) == '0)) run_last = 1'b1;
`endif

    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          op_d    = grant1 ? req1_op : req0_op;
          a_d     = grant1 ? req1_a  : req0_a;
          b_d     = grant1 ? req1_b  : req0_b;
          id_d    = grant1;
          last_d  = grant1;
          state_d = PREP;
        end
      end
      PREP: begin
        if (op_q[2]) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_id_d    = id_q;
          rsp_lo_d    = '0;
          rsp_hi_d    = '0;
        end else if (is_div && (b_q == '0)) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_id_d    = id_q;
          rsp_lo_d    = '1;
          rsp_hi_d    = a_q;
        end else begin
          sa_d    = neg_a;
          sb_d    = neg_b;
          cnt_d   = CW'(SIZE);
          opb_d   = mag_b;
          acc_d   = is_div ? {{SIZE{1'b0}}, mag_a} : '0;
          mcand_d = {{SIZE{1'b0}}, mag_a};
          state_d = RUN;
`ifdef ARITH_SCHED_EARLY_EXIT_EN
          if (!is_div && (mag_b == '0)) state_d = FIX;
`endif
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (is_div) begin
          acc_d = dshift[2*SIZE-1:0];
        end else begin
          if (opb_q[0]) acc_d = acc_q + mcand_q;
          mcand_d = mcand_q << 1;
          opb_d   = opb_q >> 1;
        end
        if (run_last) state_d = FIX;
      end
      FIX: begin
        state_d     = DONE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_id_d    = id_q;
        if (is_div) begin
          rsp_lo_d = quo;
          rsp_hi_d = rem;
        end else begin
          rsp_lo_d = prod[SIZE-1:0];
          rsp_hi_d = prod[2*SIZE-1:SIZE];
        end
      end
      DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      opb_q       <= '0;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_lo_q    <= '0;
      rsp_hi_q    <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      opb_q       <= opb_d;
      id_q        <= id_d;
      last_q      <= last_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      rsp_lo_q    <= rsp_lo_d;
      rsp_hi_q    <= rsp_hi_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_lo    = rsp_lo_q;
  assign rsp_hi    = rsp_hi_q;

endmodule

// File: tb/tb_arith_op_scheduler.sv
// tb_arith_op_scheduler: directed and random operations against an arithmetic reference model,
// plus response stall, reset abort and two-port round-robin arbitration.
module tb_arith_op_scheduler;
  localparam int SIZE = 32;

  logic            clk, rst;
  logic            req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]      req0_op, req1_op;
  logic [SIZE-1:0] req0_a, req0_b, req1_a, req1_b;
  logic            rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [SIZE-1:0] rsp_lo, rsp_hi;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        id;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  arith_op_scheduler #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, latency counted in edges after the accept edge.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] lo, output logic [31:0] hi, output logic err,
                       output int lat);
    logic [63:0] u;
    longint      sa, sb, p, q, r;
    logic [31:0] mag;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    err = 1'b0;
    lat = SIZE + 2;
    lo  = '0;
    hi  = '0;
    mag = b;
    if (op[2]) begin
      err = 1'b1;
      lat = 1;
    end else if (op[1] && b == 32'd0) begin
      err = 1'b1;
      lo  = 32'hFFFF_FFFF;
      hi  = a;
      lat = 1;
    end else begin
      case (op[1:0])
        2'b00: begin u = {32'd0, a} * {32'd0, b}; lo = u[31:0]; hi = u[63:32]; end
        2'b01: begin p = sa * sb; u = p; lo = u[31:0]; hi = u[63:32]; end
        2'b10: begin lo = a / b; hi = a % b; end
        default: begin
          q = sa / sb; r = sa % sb;
          u = q; lo = u[31:0];
          u = r; hi = u[31:0];
        end
      endcase
`ifdef ARITH_SCHED_EARLY_EXIT_EN
      if (!op[1]) begin
        if (op[0] && b[31]) mag = -b;
        lat = 2;
        for (int i = 0; i < 32; i++) if (mag[i]) lat = i + 3;
      end
`endif
    end
  endtask

  task automatic set_req(input bit port, input logic v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (port) begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 9))
      0: v = 32'd0;
      1: v = 32'd1;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = 32'h7FFF_FFFF;
      5: v = $urandom_range(0, 15);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  function automatic logic [2:0] pick_op();
    logic [2:0] o;
    o = 3'($urandom_range(0, 3));
    if ($urandom_range(0, 9) == 0) o = 3'($urandom_range(4, 7));
    return o;
  endfunction

  // One complete transaction on one port; optional response stall with the other port requesting.
  task automatic run_one(input bit port, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int stall, input bit poke);
    logic [31:0] elo, ehi;
    logic        eerr, rdy;
    int          elat, lat, w;
    model(op, a, b, elo, ehi, eerr, elat);
    @(negedge clk);
    set_req(port, 1'b1, op, a, b);
    #1;
    w   = 0;
    rdy = port ? req1_ready : req0_ready;
    while (!rdy && w < 50) begin
      @(negedge clk); #1; w++;
      rdy = port ? req1_ready : req0_ready;
    end
    chk("accept", rdy, 1'b1);
    if (!rdy) begin
      set_req(port, 1'b0, 3'd0, 32'd0, 32'd0);
      return;
    end
    @(negedge clk);
    set_req(port, 1'b0, 3'($urandom), $urandom, $urandom);
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    rsp_ready = 1'b0;
    chk("latency", lat, elat);
    chk("rsp_id", rsp_id, port);
    chk("rsp_lo", rsp_lo, elo);
    chk("rsp_hi", rsp_hi, ehi);
    chk("rsp_err", rsp_err, eerr);
    for (int i = 0; i < stall; i++) begin
      if (poke) set_req(!port, 1'b1, 3'd0, 32'd3, 32'd4);
      @(negedge clk); #1;
      chk("stall_valid", rsp_valid, 1'b1);
      chk("stall_data", {rsp_id, rsp_err, rsp_hi, rsp_lo}, {port, eerr, ehi, elo});
      chk("stall_rdy", {req0_ready, req1_ready}, 2'b00);
    end
    rsp_ready = 1'b1;
    if (poke) set_req(!port, 1'b0, 3'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("rsp_drop", rsp_valid, 1'b0);
    rsp_ready = 1'b0;
  endtask

  logic [2:0]  aop [2][4];
  logic [31:0] aa [2][4];
  logic [31:0] ab [2][4];

  initial begin
    int   idx0, idx1, got, cyc, g, prev, seen, dlat;
    logic both;
    exp_t e;
    logic [31:0] elo, ehi;
    logic        eerr;

    rst = 1'b0;
    rsp_ready = 1'b0;
    set_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    set_req(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("reset_rsp", {rsp_valid, rsp_id, rsp_err, rsp_hi, rsp_lo}, '0);
    chk("reset_rdy", {req0_ready, req1_ready}, 2'b00);
    rst = 1'b1;

    run_one(1'b0, 3'b001, 32'hFFFF_FFF9, 32'd6, 0, 1'b0);
    run_one(1'b1, 3'b011, -32'sd17, 32'd5, 0, 1'b0);
    run_one(1'b1, 3'b010, 32'd100, 32'd7, 0, 1'b0);
    run_one(1'b0, 3'b010, 32'h1234, 32'd0, 0, 1'b0);
    run_one(1'b1, 3'b011, -32'sd5, 32'd0, 0, 1'b0);
    run_one(1'b1, 3'b101, 32'd5, 32'd6, 0, 1'b0);
    run_one(1'b0, 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_one(1'b1, 3'b000, 32'hFFFF_FFFF, 32'd3, 0, 1'b0);
    run_one(1'b0, 3'b000, 32'hFFFF_FFFF, 32'd0, 0, 1'b0);
    run_one(1'b0, 3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 10, 1'b1);

    for (int n = 0; n < 40; n++)
      run_one(1'($urandom_range(0, 1)), pick_op(), pick(), pick(),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)));

    // leave nonzero response registers from port 1, then abort a port 0 multiply mid-RUN
    run_one(1'b1, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    @(negedge clk);
    set_req(1'b0, 1'b1, 3'b000, 32'h0000_0123, 32'hF000_0001);
    #1;
    chk("abort_accept", req0_ready, 1'b1);
    @(negedge clk);
    set_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_rsp", {rsp_valid, rsp_id, rsp_err, rsp_hi, rsp_lo}, '0);
    chk("abort_rdy", {req0_ready, req1_ready}, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("abort_no_rsp", seen, 0);

    // both ports request back to back; expect 0,1,0,1 grants with port 0 first after reset
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 4; i++) begin
        aop[p][i] = pick_op();
        aa[p][i]  = pick();
        ab[p][i]  = pick();
      end
    idx0 = 0; idx1 = 0; got = 0; cyc = 0; prev = 1;
    rsp_ready = 1'b1;
    while (got < 8 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (idx0 < 4) set_req(1'b0, 1'b1, aop[0][idx0], aa[0][idx0], ab[0][idx0]);
      else          set_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      if (idx1 < 4) set_req(1'b1, 1'b1, aop[1][idx1], aa[1][idx1], ab[1][idx1]);
      else          set_req(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
      #1;
      both = req0_valid && req1_valid;
      g = -1;
      if (req0_valid && req0_ready) g = 0;
      else if (req1_valid && req1_ready) g = 1;
      if (g >= 0) begin
        if (both) chk("arb_order", g, 1 - prev);
        e.id = g[0];
        if (g == 0) begin
          model(aop[0][idx0], aa[0][idx0], ab[0][idx0], elo, ehi, eerr, dlat);
          idx0++;
        end else begin
          model(aop[1][idx1], aa[1][idx1], ab[1][idx1], elo, ehi, eerr, dlat);
          idx1++;
        end
        e.lo = elo; e.hi = ehi; e.err = eerr;
        exp_q.push_back(e);
        prev = g;
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("arb_spurious", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("arb_id", rsp_id, e.id);
          chk("arb_data", {rsp_err, rsp_hi, rsp_lo}, {e.err, e.hi, e.lo});
        end
        got++;
      end
    end
    chk("arb_count", got, 8);
    set_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    set_req(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
